shift_exec_stage: RTL and testbench
===================================

// Module: shift_exec_stage
// PURPOSE
//  Two-stage pipelined RV32I shift execution unit for SLL/SRL/SRA and SLLI/SRLI/SRAI.
//  Sits between the decode/operand-fetch stage and writeback.
//  Accepts decoded shift ops over valid/ready and registers operands (S1).
//  Computes the result with one shift_left32 instance (mode tied 0); right shifts use
//  bit-reversal around that instance. Registers the result (S2) and presents it with its rd tag.
// PARAMETERS
//  TAG_W   5   width of destination-register tag carried alongside the op
//  CNT_W   16  width of retired-op counter
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      synchronous reset, active-high
//  flush       in   1      synchronous pipeline kill (redirect); same clocking as rst
//  in_valid    in   1      upstream op valid
//  in_ready    out  1      stage can accept op this cycle
//  in_op       in   2      00 SLL, 01 SRL, 11 SRA, 10 reserved
//  in_a        in   32     rs1 value (data to shift)
//  in_b        in   32     rs2 value; shamt = in_b[4:0] when in_imm_sel=0
//  in_imm_sel  in   1      1: shamt = in_imm
//  in_imm      in   5      immediate shamt
//  in_tag      in   TAG_W  destination tag
//  out_valid   out  1      result valid
//  out_ready   in   1      downstream accepts result
//  out_res     out  32     shift result
//  out_tag     out  TAG_W  tag of out_res
//  out_err     out  1      1 with out_valid when op was reserved (10)
//  retired     out  CNT_W  count of results handed off (out_valid&out_ready)
// BEHAVIOUR
//  Reset (rst=1 at edge): s1_valid=0, s2_valid=0, out_valid=0, out_res=0, out_tag=0,
//   out_err=0, retired=0. in_ready is 0 while rst=1.
//  Handshake: transfer on valid&ready; in_valid/payload held stable until accepted.
//   out_res/out_tag/out_err held stable while out_valid&!out_ready.
//  adv2 = !s2_valid | out_ready; adv1 = !s1_valid | adv2.
//  in_ready = adv1 & !flush & !rst (combinational from out_ready; no other comb paths).
//  S1 captures op, a, shamt (mux resolved at capture), tag on accept.
//   S1 valid clears if advancing with no new accept.
//  S2 loads from S1 when s1_valid&adv2.
//  Latency: accept at edge N -> out_valid at edge N+2. Throughput 1 op/cycle with out_ready=1.
//  Result (computed from S1 regs, registered into S2):
//   SLL: a << sh.  SRL: rev(shl(rev(a),sh)).
//   SRA: SRL result | (a[31] ? ~rev(shl(rev(32'hFFFFFFFF),sh)) : 0).
//   sh=0 -> res=a for all ops. Only shamt[4:0] used; in_b[31:5] ignored.
//  Reserved op 10: out_res=a unchanged, out_err=1; otherwise out_err=0.
//  retired increments on out_valid&out_ready; wraps 2^CNT_W-1 -> 0; not cleared by flush.
//  flush=1: s1_valid, s2_valid cleared next edge; no input accepted that cycle.
//   A result handed off in the flush cycle (out_valid&out_ready) still counts in retired.
//  rst and flush together: rst behaviour. rst mid-op drops all in-flight ops.
//  Backpressure full: s1_valid&s2_valid&!out_ready -> in_ready=0; no op lost or duplicated.
// TESTING
//  1 SLL a=0x0000_0001 sh=31 tag=3 -> out_res=0x8000_0000, out_tag=3, out_valid 2 cycles after accept.
//  2 SRA a=0x8000_00F0 imm sh=4 -> out_res=0xF800_000F; SRL same inputs -> 0x0800_000F;
//    SRL a=0xFFFF_FFFF, in_b=0xFFFF_FFE0 (sh=0) -> 0xFFFF_FFFF.
//  3 Stream 8 back-to-back ops, out_ready=1 -> 8 results on consecutive cycles, in order;
//    retired=8.
//  4 Stream ops, out_ready=0 for 5 cycles -> in_ready drops after 2 accepted; out_res stable;
//    release -> all results in order, no loss or duplication.
//  5 Two ops in flight, flush=1 one cycle with in_valid=1 -> op not accepted;
//    out_valid=0 next cycle; retired unchanged.
//  6 Reserved op 10 a=0x1234_5678 -> out_res=0x1234_5678, out_err=1;
//    rst mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/shift_exec_stage.sv
// Two-stage pipelined RV32I shift unit (SLL/SRL/SRA and immediate forms).
// Right shifts reuse the single left shifter by bit-reversing operand and result.

module shift_left32 (
    input  logic [31:0] data,
    input  logic [4:0]  shamt,
    input  logic        mode,
    output logic [31:0] res
);
    logic [31:0] v;

    // Log-depth barrel shifter; mode=1 rotates instead of zero-filling.
    always_comb begin
        v = data;
        for (int i = 0; i < 5; i++) begin
            if (shamt[i])
                v = (v << (1 << i)) | (mode ? (v >> (32 - (1 << i))) : 32'h0);
        end
        res = v;
    end
endmodule

module shift_exec_stage #(
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_imm_sel,
    input  logic [4:0]       in_imm,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic [CNT_W-1:0] retired
);
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b11;

    logic             s1_valid;
    logic [1:0]       s1_op;
    logic [31:0]      s1_a;
    logic [4:0]       s1_sh;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_valid;
    logic             adv1, adv2, accept;
    logic [31:0]      shl_in, shl_out, srl_res, fill, res_c;
    logic             err_c;
    logic             unused_b;

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    assign unused_b  = ^in_b[31:5];
    assign adv2      = !s2_valid || out_ready;
    assign adv1      = !s1_valid || adv2;
    assign in_ready  = adv1 && !flush && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;

    // S1 resolves the shamt source at capture so later stages see one amount.
    always_ff @(posedge clk) begin
        if (rst || flush)
            s1_valid <= 1'b0;
        else if (adv1)
            s1_valid <= accept;
        if (accept) begin
            s1_op  <= in_op;
            s1_a   <= in_a;
            s1_sh  <= in_imm_sel ? in_imm : in_b[4:0];
            s1_tag <= in_tag;
        end
    end

    // op[0] is set for both right shifts.
    assign shl_in  = s1_op[0] ? rev32(s1_a) : s1_a;
    assign srl_res = rev32(shl_out);

    shift_left32 u_shl (
        .data  (shl_in),
        .shamt (s1_sh),
        .mode  (1'b0),
        .res   (shl_out)
    );

    // Sign fill for SRA covers the top sh bits, i.e. ~(all-ones >> sh).
    always_comb begin
        fill  = '0;
        res_c = s1_a;
        err_c = 1'b0;
        for (int i = 0; i < 32; i++) fill[i] = (i + int'(s1_sh)) > 31;
        case (s1_op)
            OP_SLL:  res_c = shl_out;
            OP_SRL:  res_c = srl_res;
            OP_SRA:  res_c = srl_res | (s1_a[31] ? fill : 32'h0);
            default: err_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out_res  <= '0;
            out_tag  <= '0;
            out_err  <= 1'b0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_res <= res_c;
                out_tag <= s1_tag;
                out_err <= err_c;
            end
        end
    end

    // A hand-off in a flush cycle still counts; only rst clears the count.
    always_ff @(posedge clk) begin
        if (rst)
            retired <= '0;
        else if (s2_valid && out_ready)
            retired <= retired + CNT_W'(1);
    end
endmodule

// File: tb/tb_shift_exec_stage.sv
// Self-checking bench for shift_exec_stage: directed scenarios plus randomized traffic
// checked against an in-order FIFO reference model with arithmetic shift results.

module tb_shift_exec_stage;
    localparam int TAG_W = 5;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, in_ready, in_imm_sel;
    logic [1:0]       in_op;
    logic [31:0]      in_a, in_b, out_res;
    logic [4:0]       in_imm;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic             out_valid, out_ready, out_err;
    logic [CNT_W-1:0] retired;

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        logic             err;
        int               edge_no;
    } ent_t;

    ent_t             q[$];
    int               edge_cnt = 0;
    logic [CNT_W-1:0] exp_retired = '0;
    int               vectors = 0;
    int               miscompares = 0;
    bit               last_acc = 1'b0;

    shift_exec_stage #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .in_imm_sel(in_imm_sel), .in_imm(in_imm), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_tag(out_tag),
        .out_err(out_err), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [4:0] sh);
        case (op)
            2'b00:   return a << sh;
            2'b01:   return a >> sh;
            2'b11:   return $unsigned($signed(a) >>> sh);
            default: return a;
        endcase
    endfunction

    // A result is visible once it is the oldest in flight and has spent one edge in S1.
    function automatic bit exp_valid();
        return q.size() > 0 && edge_cnt > q[0].edge_no;
    endfunction

    function automatic bit exp_ready();
        return !rst && !flush && (q.size() < 2 || out_ready);
    endfunction

    task automatic tick();
        bit   acc, hand;
        ent_t e;
        acc       = in_valid && exp_ready();
        hand      = exp_valid() && out_ready;
        e.res     = ref_result(in_op, in_a, in_imm_sel ? in_imm : in_b[4:0]);
        e.tag     = in_tag;
        e.err     = (in_op == 2'b10);
        e.edge_no = 0;
        @(posedge clk);
        edge_cnt++;
        if (rst) begin
            q.delete();
            exp_retired = '0;
        end else begin
            if (hand) begin
                void'(q.pop_front());
                exp_retired++;
            end
            if (flush) q.delete();
            if (acc) begin
                e.edge_no = edge_cnt;
                q.push_back(e);
            end
        end
        last_acc = acc;
        #1;
    endtask

    task automatic rand_op(input bit allow_rsv);
        in_op = 2'($urandom_range(0, 3));
        if (!allow_rsv && in_op == 2'b10) in_op = 2'b11;
        in_a       = $urandom;
        in_b       = $urandom;
        in_imm_sel = 1'($urandom_range(0, 1));
        in_imm     = 5'($urandom);
        in_tag     = TAG_W'($urandom);
    endtask

    task automatic set_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic isel, input logic [4:0] imm, input logic [TAG_W-1:0] tag);
        in_op = op; in_a = a; in_b = b; in_imm_sel = isel; in_imm = imm; in_tag = tag;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        rand_op(1'b1);
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        tick();
        tick();
        vectors++;
        if ({out_valid, out_err, out_tag, out_res} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b e=%b t=%0d r=%h want all 0",
                     out_valid, out_err, out_tag, out_res);
        end
        vectors++;
        if (retired !== '0) begin
            miscompares++; $display("FAIL reset_retired: got %0d want 0", retired);
        end
        rst = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_sll_basic();
        set_op(2'b00, 32'h0000_0001, 32'd31, 1'b0, 5'd0, 5'd3);
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL sll_in_ready: got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL sll_early_valid: got %b want 0", out_valid);
        end
        tick();
        vectors++;
        if ({out_valid, out_err, out_tag, out_res} !== {1'b1, 1'b0, 5'd3, 32'h8000_0000}) begin
            miscompares++;
            $display("FAIL sll_result: got v=%b e=%b t=%0d r=%h want v=1 e=0 t=3 r=80000000",
                     out_valid, out_err, out_tag, out_res);
        end
        tick();
    endtask

    task automatic test_shift_ops();
        logic [1:0]  ops  [5] = '{2'b11, 2'b01, 2'b01, 2'b11, 2'b00};
        logic [31:0] a_v  [5] = '{32'h8000_00F0, 32'h8000_00F0, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] b_v  [5] = '{32'h1, 32'h1, 32'hFFFF_FFE0, 32'h3F, 32'h5};
        logic        sels [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [4:0]  imms [5] = '{5'd4, 5'd4, 5'd9, 5'd2, 5'd0};
        logic [31:0] want [5] = '{32'hF800_000F, 32'h0800_000F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        out_ready = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) begin
                set_op(ops[i], a_v[i], b_v[i], sels[i], imms[i], TAG_W'(i));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (i >= 1) begin
                vectors++;
                if ({out_valid, out_err, out_res} !== {1'b1, 1'b0, want[i-1]}) begin
                    miscompares++;
                    $display("FAIL shift_op%0d: got v=%b e=%b r=%h want v=1 e=0 r=%h",
                             i - 1, out_valid, out_err, out_res, want[i-1]);
                end
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [CNT_W-1:0] start = exp_retired;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                rand_op(1'b0);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (i < 8) begin
                vectors++;
                if (in_ready !== 1'b1) begin
                    miscompares++; $display("FAIL b2b_in_ready%0d: got %b want 1", i, in_ready);
                end
            end
            tick();
            vectors++;
            if (out_valid !== (i >= 1 && i <= 8)) begin
                miscompares++;
                $display("FAIL b2b_valid%0d: got %b want %b", i, out_valid, (i >= 1 && i <= 8));
            end
            if (exp_valid()) begin
                vectors++;
                if ({out_err, out_tag, out_res} !== {q[0].err, q[0].tag, q[0].res}) begin
                    miscompares++;
                    $display("FAIL b2b_data%0d: got t=%0d r=%h want t=%0d r=%h",
                             i, out_tag, out_res, q[0].tag, q[0].res);
                end
            end
        end
        vectors++;
        if (retired !== start + CNT_W'(8)) begin
            miscompares++; $display("FAIL b2b_retired: got %0d want %0d", retired, start + CNT_W'(8));
        end
    endtask

    task automatic test_backpressure();
        int acc_dut = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_op(1'b1);
        for (int c = 0; c < 13; c++) begin
            if (c == 5) begin
                vectors++;
                if (acc_dut !== 2) begin
                    miscompares++; $display("FAIL bp_accepted: got %0d want 2", acc_dut);
                end
                out_ready = 1'b1;
            end
            if (c >= 8 && last_acc) in_valid = 1'b0;
            #1;
            vectors++;
            if (in_ready !== exp_ready()) begin
                miscompares++; $display("FAIL bp_in_ready%0d: got %b want %b", c, in_ready, exp_ready());
            end
            if (in_valid && in_ready) acc_dut++;
            tick();
            if (last_acc && in_valid) rand_op(1'b1);
            vectors++;
            if (out_valid !== exp_valid() ||
                (exp_valid() && {out_err, out_tag, out_res} !== {q[0].err, q[0].tag, q[0].res})) begin
                miscompares++;
                $display("FAIL bp_out%0d: got v=%b t=%0d r=%h want v=%b", c, out_valid, out_tag,
                         out_res, exp_valid());
            end
        end
        vectors++;
        if (retired !== exp_retired || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_drain: got retired=%0d v=%b want retired=%0d v=0",
                     retired, out_valid, exp_retired);
        end
    endtask

    task automatic test_flush();
        logic [CNT_W-1:0] start;
        out_ready = 1'b0; in_valid = 1'b1;
        rand_op(1'b0); tick();
        rand_op(1'b0); tick();
        start = exp_retired;
        flush = 1'b1;
        rand_op(1'b0);
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL flush_in_ready: got %b want 0", in_ready);
        end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || retired !== start) begin
            miscompares++;
            $display("FAIL flush_kill: got v=%b retired=%0d want v=0 retired=%0d", out_valid, retired, start);
        end
        out_ready = 1'b1; in_valid = 1'b1;
        rand_op(1'b0); tick();
        in_valid = 1'b0; tick();
        start = exp_retired;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || retired !== start + CNT_W'(1)) begin
            miscompares++;
            $display("FAIL flush_handoff: got v=%b retired=%0d want v=0 retired=%0d",
                     out_valid, retired, start + CNT_W'(1));
        end
    endtask

    task automatic test_reserved_and_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        set_op(2'b10, 32'h1234_5678, $urandom, 1'($urandom), 5'($urandom), 5'd9);
        tick();
        in_valid = 1'b0;
        tick();
        vectors++;
        if ({out_valid, out_err, out_tag, out_res} !== {1'b1, 1'b1, 5'd9, 32'h1234_5678}) begin
            miscompares++;
            $display("FAIL reserved: got v=%b e=%b t=%0d r=%h want v=1 e=1 t=9 r=12345678",
                     out_valid, out_err, out_tag, out_res);
        end
        out_ready = 1'b0; in_valid = 1'b1;
        rand_op(1'b0); tick();
        rand_op(1'b0); tick();
        rst = 1'b1;
        rand_op(1'b0);
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL midrst_in_ready: got %b want 0", in_ready);
        end
        tick();
        rst = 1'b0; in_valid = 1'b0;
        vectors++;
        if ({out_valid, out_err, out_tag, out_res, retired} !== '0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got v=%b e=%b t=%0d r=%h retired=%0d want all 0",
                     out_valid, out_err, out_tag, out_res, retired);
        end
    endtask

    task automatic test_random();
        in_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                rand_op(1'b1);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            #1;
            vectors++;
            if (in_ready !== exp_ready()) begin
                miscompares++; $display("FAIL rnd_in_ready%0d: got %b want %b", c, in_ready, exp_ready());
            end
            tick();
            vectors++;
            if (out_valid !== exp_valid() || retired !== exp_retired ||
                (exp_valid() && {out_err, out_tag, out_res} !== {q[0].err, q[0].tag, q[0].res})) begin
                miscompares++;
                $display("FAIL rnd_out%0d: got v=%b e=%b t=%0d r=%h retired=%0d want v=%b retired=%0d",
                         c, out_valid, out_err, out_tag, out_res, retired, exp_valid(), exp_retired);
            end
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_op(2'b00, 32'h0, 32'h0, 1'b0, 5'd0, '0);
        test_reset();
        test_sll_basic();
        test_shift_ops();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reserved_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
